mac_col_pipe_gated: RTL and testbench

//  Parametrised, pipelined successor to the zero-gated MAC column for the attention (Q*K^T) systolic array.
//  - Captures one key vector per column during the load phase.
//  - Streams query vectors through the column and forwards them to the next column.
//  - Emits one signed dot product per execute cycle to the column's output FIFO.
//  - Zero lanes (q_zero/k_zero) hold operands and force the product to 0, saving switching power.

---
 rtl/mac_col_pipe_gated.sv | 162 ++++++++++++++++
 tb/tb_mac_col_pipe_gated.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_col_pipe_gated.sv
// rtl/mac_col_pipe_gated.sv - pipelined zero-gated MAC column for the Q*K^T systolic array
// Optional MAC_COL_ACC_EN adds acc_clr and accumulates results across K-chunks.
module mac_col_pipe_gated #(
    parameter int bw      = 8,
    parameter int pr      = 8,
    parameter int bw_psum = 2*bw + $clog2(pr) + 3,
    parameter int col_id  = 0,
    parameter int num_col = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           i_inst,
    input  logic [pr*bw-1:0]     q_in,
    input  logic [pr-1:0]        q_zero,
    input  logic [pr-1:0]        k_zero,
`ifdef MAC_COL_ACC_EN
    input  logic                 acc_clr,
`endif
    output logic [pr*bw-1:0]     q_out,
    output logic [1:0]           o_inst,
    output logic [bw_psum-1:0]   out,
    output logic                 fifo_wr
);

    localparam int CW = (num_col > 1) ? $clog2(num_col) : 1;
    localparam logic [CW-1:0] CAP_CNT = CW'(num_col - 1 - col_id);
    localparam logic [CW-1:0] MAX_CNT = CW'(num_col - 1);

    logic [1:0]            inst_q, inst_d;
    logic [pr*bw-1:0]      qin_q, qin_d;
    logic [pr-1:0]         qzi_q, qzi_d, kzi_q, kzi_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  load_ready_q, load_ready_d;
    logic [pr*bw-1:0]      key_q, key_d;
    logic [pr-1:0]         kz_reg_q, kz_reg_d;
    logic                  v1_q, v1_d, v2_q, v2_d;
    logic [pr*bw-1:0]      query_q, query_d;
    logic [pr-1:0]         qz_reg_q, qz_reg_d;
    logic [pr*2*bw-1:0]    prod_q, prod_d;
    logic [bw_psum-1:0]    out_q, out_d;
    logic                  fifo_wr_q, fifo_wr_d;
    logic                  acl0_q, acl0_d, acl1_q, acl1_d, acl2_q, acl2_d;
    logic                  exec;
    logic signed [bw_psum-1:0] sum;
    logic [bw_psum-1:0]    base;

    always_comb begin
        inst_d       = i_inst;
        qin_d        = q_in;
        qzi_d        = q_zero;
        kzi_d        = k_zero;
`ifdef MAC_COL_ACC_EN
        acl0_d       = acc_clr;
`else
        acl0_d       = 1'b1;
`endif
        cnt_d        = cnt_q;
        load_ready_d = load_ready_q;
        key_d        = key_q;
        kz_reg_d     = kz_reg_q;

        // Column col_id grabs the key that reaches it num_col-1-col_id cycles into the load.
        if (inst_q[0]) begin
            if (load_ready_q) begin
                if (cnt_q == CAP_CNT) begin
                    key_d        = qin_q;
                    kz_reg_d     = kzi_q;
                    cnt_d        = '0;
                    load_ready_d = 1'b0;
                end else if (cnt_q != MAX_CNT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else begin
            cnt_d        = '0;
            load_ready_d = 1'b1;
        end

        exec     = inst_q[1] & ~inst_q[0];
        v1_d     = exec;
        acl1_d   = acl0_q;
        query_d  = query_q;
        qz_reg_d = qz_reg_q;
        if (exec) begin
            qz_reg_d = qzi_q;
            for (int k = 0; k < pr; k++) begin
                if (!qzi_q[k]) query_d[k*bw +: bw] = qin_q[k*bw +: bw];
            end
        end

        // Gated lanes keep query/key frozen so the multiplier inputs do not toggle.
        v2_d   = v1_q;
        acl2_d = acl1_q;
        prod_d = prod_q;
        if (v1_q) begin
            for (int k = 0; k < pr; k++) begin
                if (qz_reg_q[k] | kz_reg_q[k])
                    prod_d[k*2*bw +: 2*bw] = '0;
                else
                    prod_d[k*2*bw +: 2*bw] = $signed(query_q[k*bw +: bw]) * $signed(key_q[k*bw +: bw]);
            end
        end

        sum = '0;
        for (int k = 0; k < pr; k++) begin
            sum = sum + bw_psum'($signed(prod_q[k*2*bw +: 2*bw]));
        end

        base      = acl2_q ? '0 : out_q;
        fifo_wr_d = v2_q;
        out_d     = out_q;
        if (v2_q) out_d = base + sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_q       <= '0;
            qin_q        <= '0;
            qzi_q        <= '0;
            kzi_q        <= '0;
            cnt_q        <= '0;
            load_ready_q <= 1'b1;
            key_q        <= '0;
            kz_reg_q     <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            query_q      <= '0;
            qz_reg_q     <= '0;
            prod_q       <= '0;
            out_q        <= '0;
            fifo_wr_q    <= 1'b0;
            acl0_q       <= 1'b0;
            acl1_q       <= 1'b0;
            acl2_q       <= 1'b0;
        end else begin
            inst_q       <= inst_d;
            qin_q        <= qin_d;
            qzi_q        <= qzi_d;
            kzi_q        <= kzi_d;
            cnt_q        <= cnt_d;
            load_ready_q <= load_ready_d;
            key_q        <= key_d;
            kz_reg_q     <= kz_reg_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            query_q      <= query_d;
            qz_reg_q     <= qz_reg_d;
            prod_q       <= prod_d;
            out_q        <= out_d;
            fifo_wr_q    <= fifo_wr_d;
            acl0_q       <= acl0_d;
            acl1_q       <= acl1_d;
            acl2_q       <= acl2_d;
        end
    end

    assign q_out   = qin_q;
    assign o_inst  = inst_q;
    assign out     = out_q;
    assign fifo_wr = fifo_wr_q;

endmodule

// File: tb/tb_mac_col_pipe_gated.sv
// tb/tb_mac_col_pipe_gated.sv - directed vector bench for mac_col_pipe_gated (col_id=2, num_col=8)
module tb_mac_col_pipe_gated;

    localparam int BW  = 8;
    localparam int PR  = 8;
    localparam int BWP = 22;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      i_inst;
    logic [PR*BW-1:0] q_in;
    logic [PR-1:0]   q_zero, k_zero;
    logic [PR*BW-1:0] q_out;
    logic [1:0]      o_inst;
    logic [BWP-1:0]  out;
    logic            fifo_wr;
`ifdef MAC_COL_ACC_EN
    logic            acc_clr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mac_col_pipe_gated #(.bw(BW), .pr(PR), .bw_psum(BWP), .col_id(2), .num_col(8)) dut (
        .clk(clk), .reset(reset), .i_inst(i_inst), .q_in(q_in), .q_zero(q_zero), .k_zero(k_zero),
`ifdef MAC_COL_ACC_EN
        .acc_clr(acc_clr),
`endif
        .q_out(q_out), .o_inst(o_inst), .out(out), .fifo_wr(fifo_wr)
    );

    typedef struct {
        string       name;
        logic [63:0] key;
        logic [7:0]  kz;
        logic [63:0] qry;
        logic [7:0]  qz;
        int          exp;
    } vec_t;

    vec_t vt[5];

    localparam logic [63:0] KEYS_1_8 = 64'h0807060504030201;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_keys(input logic [63:0] kv, input logic [7:0] kz);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            i_inst = 2'b01;
            q_in   = (i == 5) ? kv : {8{8'(i + 8'h30)}};
            k_zero = (i == 5) ? kz : 8'hFF;
            q_zero = '0;
        end
        @(negedge clk);
        i_inst = 2'b00;
        q_in   = '0;
        k_zero = '0;
    endtask

    task automatic exec_check(input string name, input logic [63:0] qry, input logic [7:0] qz, input int exp);
        @(negedge clk);
        i_inst = 2'b10;
        q_in   = qry;
        q_zero = qz;
`ifdef MAC_COL_ACC_EN
        acc_clr = 1'b1;
`endif
        @(negedge clk);
        i_inst = 2'b00;
        q_in   = '0;
        q_zero = '0;
`ifdef MAC_COL_ACC_EN
        acc_clr = 1'b0;
`endif
        chk({name, " o_inst"}, 64'(o_inst), 64'(2'b10));
        chk({name, " q_out"}, q_out, qry);
        @(negedge clk);
        @(negedge clk);
        chk({name, " early fifo_wr"}, 64'(fifo_wr), 0);
        @(negedge clk);
        chk({name, " fifo_wr"}, 64'(fifo_wr), 1);
        chk({name, " out"}, $signed(out), exp);
        @(negedge clk);
        chk({name, " fifo_wr drop"}, 64'(fifo_wr), 0);
        chk({name, " out hold"}, $signed(out), exp);
    endtask

    initial begin
        vt[0] = '{"dot72",   KEYS_1_8,              8'h00, {8{8'd2}},              8'h00, 72};
        vt[1] = '{"gating",  {8{8'hFF}},            8'h80, 64'h0303030363636363,   8'h0F, -9};
        vt[2] = '{"extreme", {8{8'h80}},            8'h00, {8{8'h80}},             8'h00, 131072};
        vt[3] = '{"alt",     KEYS_1_8,              8'h00, 64'hFF01FF01FF01FF01,   8'h00, -4};
        vt[4] = '{"negmax",  {8{8'h7F}},            8'h00, {8{8'h80}},             8'h00, -130048};

        reset = 1'b1; i_inst = '0; q_in = '0; q_zero = '0; k_zero = '0;
`ifdef MAC_COL_ACC_EN
        acc_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst out", $signed(out), 0);
        chk("rst fifo_wr", 64'(fifo_wr), 0);
        chk("rst q_out", q_out, 0);
        chk("rst o_inst", 64'(o_inst), 0);
        chk("rst load_ready", 64'(dut.load_ready_q), 1);

        // key capture: lane value = load cycle index, column 2 of 8 keeps cycle 5
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            i_inst = 2'b01;
            q_in   = {8{8'(i)}};
        end
        @(negedge clk);
        i_inst = 2'b00;
        q_in   = '0;
        chk("cap key", dut.key_q, {8{8'd5}});
        chk("cap load_ready", 64'(dut.load_ready_q), 0);
        repeat (2) @(negedge clk);
        chk("rearm load_ready", 64'(dut.load_ready_q), 1);
        chk("rearm cnt", 64'(dut.cnt_q), 0);

        for (int v = 0; v < 5; v++) begin
            load_keys(vt[v].key, vt[v].kz);
            exec_check(vt[v].name, vt[v].qry, vt[v].qz, vt[v].exp);
        end

        // gated lanes must keep the query from the previous execute
        load_keys(KEYS_1_8, 8'h00);
        exec_check("pre gate", {8{8'd2}}, 8'h00, 72);
        exec_check("post gate", 64'h0303030363636363, 8'h0F, 78);
        chk("gate hold lanes", 64'(dut.query_q[31:0]), 64'(32'h02020202));

        // load+execute together is a load only
        @(negedge clk);
        i_inst = 2'b11;
        q_in   = {8{8'd9}};
        @(negedge clk);
        i_inst = 2'b00;
        q_in   = '0;
        chk("ld+ex o_inst", 64'(o_inst), 64'(2'b11));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ld+ex fifo_wr", 64'(fifo_wr), 0);
        end
        chk("ld+ex key kept", dut.key_q, KEYS_1_8);

        // back-to-back executes
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_inst = 2'b10;
            q_in   = (i == 0) ? {8{8'd1}} : (i == 1) ? {8{8'd2}} : {8{8'hFF}};
`ifdef MAC_COL_ACC_EN
            acc_clr = 1'b1;
`endif
        end
        @(negedge clk);
        i_inst = 2'b00;
        q_in   = '0;
        @(negedge clk);
        chk("b2b0 fifo_wr", 64'(fifo_wr), 1);
        chk("b2b0 out", $signed(out), 36);
        @(negedge clk);
        chk("b2b1 fifo_wr", 64'(fifo_wr), 1);
        chk("b2b1 out", $signed(out), 72);
        @(negedge clk);
        chk("b2b2 fifo_wr", 64'(fifo_wr), 1);
        chk("b2b2 out", $signed(out), -36);
        @(negedge clk);
        chk("b2b end fifo_wr", 64'(fifo_wr), 0);
        chk("b2b end out hold", $signed(out), -36);

`ifdef MAC_COL_ACC_EN
        // accumulate across three chunks, dot = 10 each
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_inst  = 2'b10;
            q_in    = 64'h0000000001010101;
            acc_clr = (i == 0);
        end
        @(negedge clk);
        i_inst  = 2'b00;
        q_in    = '0;
        acc_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("acc fifo_wr", 64'(fifo_wr), 1);
            chk("acc out", $signed(out), 10 * (i + 1));
        end
`endif

        // reset with three executes in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_inst = 2'b10;
            q_in   = {8{8'd1}};
        end
        @(negedge clk);
        i_inst = 2'b00;
        q_in   = '0;
        reset  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst fifo_wr", 64'(fifo_wr), 0);
        chk("midrst out", $signed(out), 0);
        chk("midrst key", dut.key_q, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst drain fifo_wr", 64'(fifo_wr), 0);
        end
        load_keys(KEYS_1_8, 8'h00);
        exec_check("recapture", {8{8'd2}}, 8'h00, 72);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

endmodule
